// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM access sequencer.
package sram_ctrl_pkg;

  // Sequencer phases: one request at a time walks PRE -> WL -> (SENSE) -> RESP.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    WL    = 3'd2,
    SENSE = 3'd3,
    RESP  = 3'd4
  } ctrl_state_t;

  localparam int PRE_CYC_DEF = 1;
  localparam int WL_CYC_DEF  = 2;

  // Phase counter width: wide enough to hold the longer of the two phase lengths.
  function automatic int cnt_width(input int pre_cyc, input int wl_cyc);
    int m;
    m = (pre_cyc > wl_cyc) ? pre_cyc : wl_cyc;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_access_ctrl_phase_timer.sv
// Loadable down-counter that times one sequencer phase. It is reloaded at the
// start of every phase and parks at 1; done_o marks the last cycle of a phase.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise step down and stop at 1 (never wraps).
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q > W'(1))
      cnt_d = cnt_q - W'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/sram_access_ctrl.sv
// Request sequencer in front of the SRAM row decoder: latches the row address,
// then drives precharge, wordline (+write drivers) and sense enables in turn,
// and returns a response. All control outputs come straight from flops.
// PRE_CYC and WL_CYC must both be at least 1.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int PRE_CYC = PRE_CYC_DEF,
  parameter int WL_CYC  = WL_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] row_addr,
  output logic              pre_en,
  output logic              wl_en,
  output logic              wr_drv,
  output logic [DATA_W-1:0] bl_wdata,
  output logic              se_en,
  input  logic [DATA_W-1:0] sa_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata
);

  localparam int CNT_W = cnt_width(PRE_CYC, WL_CYC);
  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYC);
  localparam logic [CNT_W-1:0] WL_LD  = CNT_W'(WL_CYC);

  ctrl_state_t       state_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [DATA_W-1:0] bl_wdata_q, bl_wdata_d;
  logic              pre_en_q, wl_en_q, wr_drv_q, se_en_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              accept;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;

  // Ready is a pure decode of the IDLE state, masked by reset so nothing is
  // accepted on a reset edge and the first accept can land right after release.
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Reload the phase timer on entry to PRE (accept) and on entry to WL.
  always_comb begin
    tmr_load = accept || ((state_q == PRE) && tmr_done);
    tmr_val  = (state_q == IDLE) ? PRE_LD : WL_LD;
  end

  phase_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Request capture: address, write data and direction hold until the next accept.
  always_comb begin
    row_addr_d = row_addr_q;
    bl_wdata_d = bl_wdata_q;
    we_d       = we_q;
    if (accept) begin
      row_addr_d = req_addr;
      bl_wdata_d = req_wdata;
      we_d       = req_we;
    end
  end

  // Request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_addr_q <= '0;
      bl_wdata_q <= '0;
      we_q       <= 1'b0;
    end else begin
      row_addr_q <= row_addr_d;
      bl_wdata_q <= bl_wdata_d;
      we_q       <= we_d;
    end
  end

  // Sequencer FSM with registered enables; each enable is set on entry to its
  // phase and cleared on exit, so the three phase enables can never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pre_en_q    <= 1'b0;
      wl_en_q     <= 1'b0;
      wr_drv_q    <= 1'b0;
      se_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= PRE;
            pre_en_q <= 1'b1;
          end
        end
        PRE: begin
          if (tmr_done) begin
            state_q  <= WL;
            pre_en_q <= 1'b0;
            wl_en_q  <= 1'b1;
            wr_drv_q <= we_q;
          end
        end
        WL: begin
          if (tmr_done) begin
            wl_en_q  <= 1'b0;
            wr_drv_q <= 1'b0;
            if (we_q) begin
              // Writes skip sensing and answer with zero data.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= SENSE;
              se_en_q <= 1'b1;
            end
          end
        end
        SENSE: begin
          // Sense amp output is sampled on the closing edge of the sense cycle.
          state_q     <= RESP;
          se_en_q     <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= sa_rdata;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign row_addr  = row_addr_q;
  assign bl_wdata  = bl_wdata_q;
  assign pre_en    = pre_en_q;
  assign wl_en     = wl_en_q;
  assign wr_drv    = wr_drv_q;
  assign se_en     = se_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two instances (default phase lengths and
// PRE=3/WL=4) share one stimulus stream; a timeline model per instance gives
// the expected outputs every cycle, and directed sequences pin exact timings.
module tb_sram_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_we, rsp_ready;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata, sa_rdata;

  logic        req_ready [2];
  logic        pre_en    [2];
  logic        wl_en     [2];
  logic        wr_drv    [2];
  logic        se_en     [2];
  logic        rsp_valid [2];
  logic [3:0]  row_addr  [2];
  logic [15:0] bl_wdata  [2];
  logic [15:0] rsp_rdata [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  function automatic int pc(input int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int wc(input int i); return (i == 0) ? 2 : 4; endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_access_ctrl #(
      .ADDR_W (4), .DATA_W (16),
      .PRE_CYC ((g == 0) ? 1 : 3), .WL_CYC ((g == 0) ? 2 : 4)
    ) u_dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid), .req_ready (req_ready[g]), .req_we (req_we),
      .req_addr (req_addr), .req_wdata (req_wdata),
      .row_addr (row_addr[g]), .pre_en (pre_en[g]), .wl_en (wl_en[g]),
      .wr_drv (wr_drv[g]), .bl_wdata (bl_wdata[g]), .se_en (se_en[g]),
      .sa_rdata (sa_rdata), .rsp_valid (rsp_valid[g]), .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata[g])
    );
  end

  task automatic check(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h want %0h", nm, i, $time, got, exp);
    end
  endtask

  // Timeline model: a transaction is just "k cycles since accept".
  bit          m_busy [2] = '{0, 0};
  int          m_k    [2] = '{0, 0};
  bit          m_we   [2] = '{0, 0};
  logic [3:0]  m_ra   [2] = '{4'd0, 4'd0};
  logic [15:0] m_bw   [2] = '{16'd0, 16'd0};
  logic [15:0] m_rd   [2] = '{16'd0, 16'd0};

  always @(posedge clk) begin : model
    int p, w, rl;
    for (int i = 0; i < 2; i++) begin
      p = pc(i); w = wc(i);
      if (rst) begin
        m_busy[i] = 0; m_k[i] = 0; m_ra[i] = '0; m_bw[i] = '0; m_rd[i] = '0; m_we[i] = 0;
      end else if (!m_busy[i]) begin
        if (req_valid) begin
          m_busy[i] = 1; m_k[i] = 1; m_we[i] = req_we; m_ra[i] = req_addr; m_bw[i] = req_wdata;
        end
      end else begin
        rl = m_we[i] ? p + w + 1 : p + w + 2;
        if (m_k[i] >= rl && rsp_ready) begin
          m_busy[i] = 0;
        end else begin
          if (!m_we[i] && m_k[i] == p + w + 1) m_rd[i] = sa_rdata;
          if (m_we[i] && m_k[i] == p + w) m_rd[i] = '0;
          m_k[i]++;
        end
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin : compare
    int p, w, k, rl;
    logic e_pre, e_wl, e_se, e_rv, e_rdy;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        p = pc(i); w = wc(i); k = m_k[i];
        rl = m_we[i] ? p + w + 1 : p + w + 2;
        e_pre = m_busy[i] && k >= 1 && k <= p;
        e_wl  = m_busy[i] && k > p && k <= p + w;
        e_se  = m_busy[i] && !m_we[i] && k == p + w + 1;
        e_rv  = m_busy[i] && k >= rl;
        e_rdy = !rst && !m_busy[i];
        check("req_ready", i, 32'(req_ready[i]), 32'(e_rdy));
        check("pre_en",    i, 32'(pre_en[i]),    32'(e_pre));
        check("wl_en",     i, 32'(wl_en[i]),     32'(e_wl));
        check("wr_drv",    i, 32'(wr_drv[i]),    32'(e_wl && m_we[i]));
        check("se_en",     i, 32'(se_en[i]),     32'(e_se));
        check("rsp_valid", i, 32'(rsp_valid[i]), 32'(e_rv));
        check("rsp_rdata", i, 32'(rsp_rdata[i]), 32'(m_rd[i]));
        check("row_addr",  i, 32'(row_addr[i]),  32'(m_ra[i]));
        check("bl_wdata",  i, 32'(bl_wdata[i]),  32'(m_bw[i]));
        check("excl", i, 32'((pre_en[i] & wl_en[i]) | (pre_en[i] & se_en[i]) | (wl_en[i] & se_en[i])), 32'd0);
        check("wr_in_wl", i, 32'(wr_drv[i] & !wl_en[i]), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 100) begin tick(); n++; end
    check("ready_within_bound", i, 32'(req_ready[i]), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1; req_valid = 1; req_we = 0; req_addr = 4'd3; req_wdata = '0;
    rsp_ready = 1; sa_rdata = '0;

    // Reset held with a pending request.
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_ready",  i, 32'(req_ready[i]), 32'd0);
      check("rst_pre",    i, 32'(pre_en[i]),    32'd0);
      check("rst_rv",     i, 32'(rsp_valid[i]), 32'd0);
      check("rst_row",    i, 32'(row_addr[i]),  32'd0);
      check("rst_rdata",  i, 32'(rsp_rdata[i]), 32'd0);
    end
    rst = 0; #1;
    check("ready_after_release", 0, 32'(req_ready[0]), 32'd1);
    tick();
    check("first_accept_pre", 0, 32'(pre_en[0]), 32'd1);
    check("first_accept_row", 0, 32'(row_addr[0]), 32'd3);
    req_valid = 0;

    // Read addr 9, default timing.
    wait_ready(0);
    sa_rdata = 16'hA5C3; req_valid = 1; req_we = 0; req_addr = 4'd9;
    tick(); req_valid = 0;
    check("rd_pre_t1", 0, 32'(pre_en[0]), 32'd1);
    check("rd_row_t1", 0, 32'(row_addr[0]), 32'd9);
    tick(); check("rd_wl_t2", 0, 32'(wl_en[0]), 32'd1);
    tick(); check("rd_wl_t3", 0, 32'(wl_en[0]), 32'd1);
    tick(); check("rd_se_t4", 0, 32'(se_en[0]), 32'd1);
    tick(); check("rd_rv_t5", 0, 32'(rsp_valid[0]), 32'd1);
    check("rd_data_t5", 0, 32'(rsp_rdata[0]), 32'hA5C3);
    check("rd_row_t5", 0, 32'(row_addr[0]), 32'd9);
    tick(); check("rd_idle_t6", 0, 32'(req_ready[0]), 32'd1);

    // Write addr 15, data 1234.
    wait_ready(0);
    req_valid = 1; req_we = 1; req_addr = 4'd15; req_wdata = 16'h1234;
    tick(); req_valid = 0;
    check("wr_pre_t1", 0, 32'(pre_en[0]), 32'd1);
    for (int c = 2; c <= 3; c++) begin
      tick();
      check("wr_wl", 0, 32'(wl_en[0]), 32'd1);
      check("wr_drv", 0, 32'(wr_drv[0]), 32'd1);
      check("wr_bl", 0, 32'(bl_wdata[0]), 32'h1234);
      check("wr_no_se", 0, 32'(se_en[0]), 32'd0);
    end
    tick(); check("wr_rv_t4", 0, 32'(rsp_valid[0]), 32'd1);
    check("wr_data_t4", 0, 32'(rsp_rdata[0]), 32'd0);

    // Back-pressured response; a request during RESP must wait.
    wait_ready(0);
    sa_rdata = 16'hBEEF; req_valid = 1; req_we = 0; req_addr = 4'd5;
    tick(); req_valid = 0; rsp_ready = 0;
    repeat (4) tick();
    sa_rdata = 16'h0F0F; req_valid = 1; req_addr = 4'd7;
    for (int j = 0; j < 3; j++) begin
      check("hold_rv", 0, 32'(rsp_valid[0]), 32'd1);
      check("hold_data", 0, 32'(rsp_rdata[0]), 32'hBEEF);
      check("hold_ready", 0, 32'(req_ready[0]), 32'd0);
      check("hold_row", 0, 32'(row_addr[0]), 32'd5);
      tick();
    end
    rsp_ready = 1;
    check("hold_rv_last", 0, 32'(rsp_valid[0]), 32'd1);
    tick();
    check("post_hs_rv", 0, 32'(rsp_valid[0]), 32'd0);
    check("post_hs_ready", 0, 32'(req_ready[0]), 32'd1);
    check("post_hs_row", 0, 32'(row_addr[0]), 32'd5);
    tick();
    check("next_accept_pre", 0, 32'(pre_en[0]), 32'd1);
    check("next_accept_row", 0, 32'(row_addr[0]), 32'd7);
    req_valid = 0;

    // Reset during the wordline phase of a read.
    wait_ready(0);
    req_valid = 1; req_we = 0; req_addr = 4'd12;
    tick(); req_valid = 0;
    tick(); check("mid_wl", 0, 32'(wl_en[0]), 32'd1);
    rst = 1;
    tick();
    check("mid_rst_wl", 0, 32'(wl_en[0]), 32'd0);
    check("mid_rst_rv", 0, 32'(rsp_valid[0]), 32'd0);
    rst = 0;
    repeat (8) begin check("no_rsp_after_rst", 0, 32'(rsp_valid[0]), 32'd0); tick(); end
    wait_ready(0);
    sa_rdata = 16'h5A5A; req_valid = 1; req_addr = 4'd0;
    tick(); req_valid = 0;
    n = 1;
    while (rsp_valid[0] !== 1'b1 && n < 20) begin tick(); n++; end
    check("addr0_latency", 0, 32'(n), 32'd5);
    check("addr0_data", 0, 32'(rsp_rdata[0]), 32'h5A5A);
    check("addr0_row", 0, 32'(row_addr[0]), 32'd0);

    // Long phases: all 16 rows, even = read (t+9), odd = write (t+8).
    for (int a = 0; a < 16; a++) begin
      int lat;
      req_valid = 0;
      wait_ready(1);
      req_valid = 1; req_addr = a[3:0]; req_we = a[0];
      req_wdata = 16'($urandom); sa_rdata = 16'($urandom);
      lat = a[0] ? 8 : 9;
      tick(); req_valid = 0;
      repeat (lat - 2) tick();
      check("long_rv_early", 1, 32'(rsp_valid[1]), 32'd0);
      tick();
      check("long_rv", 1, 32'(rsp_valid[1]), 32'd1);
      check("long_row", 1, 32'(row_addr[1]), 32'(a[3:0]));
    end

    // Random traffic against the model.
    repeat (3000) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 9) < 6);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom);
      req_wdata = 16'($urandom);
      sa_rdata  = 16'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 0; req_valid = 0; rsp_ready = 1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
